// File: rtl/ixc_capture_pkg.sv
// Shared types and constants for the 8-bit net snapshot reader.
package ixc_capture_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BASE = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Default geometry of the reader.
  localparam int CAP_WIDTH   = 8;
  localparam int CAP_DEPTH   = 4;
  localparam int CAP_STAMP_W = 16;

  // One buffered snapshot; the stamp sits in the upper bits.
  typedef struct packed {
    logic [CAP_STAMP_W-1:0] stamp;
    logic [CAP_WIDTH-1:0]   data;
  } entry_t;

  // Occupancy counters need one extra bit so that "full" (== DEPTH) fits.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CAP_LEVEL_W = $clog2(CAP_DEPTH) + 1;

endpackage

// File: rtl/ixc_capture_fifo.sv
// First-word fall-through snapshot buffer. Pointers carry one extra bit
// above the index so that full and empty are told apart without a counter.
module ixc_capture_fifo
  import ixc_capture_pkg::*;
#(
  parameter int W     = $bits(entry_t),
  parameter int DEPTH = CAP_DEPTH,
  localparam int LW   = level_w(DEPTH),
  localparam int AW   = LW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;
  logic [DEPTH-1:0] w_we;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_level = r_wr_ptr - r_rd_ptr;

  // A push into a full buffer is still accepted when the head leaves in the
  // same cycle: the freed slot is the one being written.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head is read combinationally; it stays put until a pop moves r_rd_ptr.
  assign o_rdata = o_empty ? '0 : r_mem[w_rd_idx];

  // One write enable per slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign w_we[gi] = w_do_push && (w_wr_idx == AW'(gi));
  end

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
    end
  end

  // Entry storage, cleared on reset so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) r_mem[i] <= i_wdata;
      end
    end
  end

endmodule

// File: rtl/ixc_capture_8.sv
// Snapshot reader for an 8-bit emulated net: request- or change-triggered
// captures, time-stamped and queued for the host readback stream.
module ixc_capture_8
  import ixc_capture_pkg::*;
#(
  parameter int WIDTH    = CAP_WIDTH,
  parameter int DEPTH    = CAP_DEPTH,
  parameter int STAMP_W  = CAP_STAMP_W,
  localparam int LEVEL_W = level_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   R,
  input  logic               arm,
  input  logic               mode,
  input  logic               req,
  output logic [WIDTH-1:0]   out_data,
  output logic [STAMP_W-1:0] out_stamp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  input  logic               clr_ovf
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_mode;
  logic [STAMP_W-1:0]   r_stamp;
  logic [WIDTH-1:0]     r_prev;
  logic                 r_overflow;
  logic                 w_capture;
  logic                 w_load_prev;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_drop;
  logic [STAMP_W+WIDTH-1:0] w_rdata;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state: disarming always returns to IDLE; BASE lasts one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (arm) w_state_next = BASE;
      BASE:    w_state_next = arm ? RUN : IDLE;
      RUN:     if (!arm) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Capture decision. Change mode takes an unconditional baseline in BASE,
  // then compares against the previous-value register every RUN cycle.
  always_comb begin
    w_capture   = 1'b0;
    w_load_prev = 1'b0;
    case (r_state)
      BASE, RUN: begin
        if (arm) begin
          if (r_mode) begin
            w_capture   = (r_state == BASE) || (R != r_prev);
            w_load_prev = 1'b1;
          end else begin
            w_capture   = req;
          end
        end
      end
      default: begin
        w_capture   = 1'b0;
        w_load_prev = 1'b0;
      end
    endcase
  end

  // Mode is only tracked while idle so an armed session keeps its mode.
  always_ff @(posedge clk) begin
    if (rst)                  r_mode <= 1'b0;
    else if (r_state == IDLE) r_mode <= mode;
  end

  // Free-running cycle stamp, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) r_stamp <= '0;
    else     r_stamp <= r_stamp + STAMP_W'(1);
  end

  // Previous net value for change detection.
  always_ff @(posedge clk) begin
    if (rst)              r_prev <= '0;
    else if (w_load_prev) r_prev <= R;
  end

  assign w_pop  = out_ready && !w_empty;
  assign w_drop = w_capture && w_full && !w_pop;

  // Sticky overflow; a new drop beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)          r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (clr_ovf) r_overflow <= 1'b0;
  end

  ixc_capture_fifo #(
    .W     (STAMP_W + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_capture),
    .i_wdata ({r_stamp, R}),
    .i_pop   (out_ready),
    .o_rdata (w_rdata),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_rdata[WIDTH-1:0];
  assign out_stamp = w_rdata[STAMP_W+WIDTH-1:WIDTH];
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ixc_capture_8.sv
// Directed bench for ixc_capture_8: request mode, change mode, overflow,
// full-with-pop, stamp wrap and mid-run reset.
module tb_ixc_capture_8;
  import ixc_capture_pkg::*;

  logic                   clk;
  logic                   rst;
  logic [7:0]             R;
  logic                   arm;
  logic                   mode;
  logic                   req;
  logic [7:0]             out_data;
  logic [15:0]            out_stamp;
  logic                   out_valid;
  logic                   out_ready;
  logic [CAP_LEVEL_W-1:0] level;
  logic                   overflow;
  logic                   clr_ovf;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] cnt;   // mirror of the stamp the DUT should hold right now
  logic [15:0] s0;
  logic [15:0] sa;
  logic [7:0]  exp_q [4];

  ixc_capture_8 dut (
    .clk       (clk),
    .rst       (rst),
    .R         (R),
    .arm       (arm),
    .mode      (mode),
    .req       (req),
    .out_data  (out_data),
    .out_stamp (out_stamp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    logic r_at_edge;
    r_at_edge = rst;
    @(posedge clk);
    #1;
    cnt = r_at_edge ? 16'd0 : cnt + 16'd1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; R = 8'h00; arm = 1'b0; mode = 1'b0; req = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0; cnt = 16'd0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data",  32'(out_data),  32'h0);
    check("rst_stamp", 32'(out_stamp), 32'h0);
    check("rst_level", 32'(level),     32'h0);
    check("rst_ovf",   32'(overflow),  32'h0);

    // Request mode: req at stamp 10.
    rst = 1'b0; arm = 1'b1; mode = 1'b0; R = 8'h5A;
    tick(); tick();                       // IDLE->BASE->RUN, no req in BASE
    while (cnt != 16'd10) tick();
    check("req_pre_valid", 32'(out_valid), 32'h0);
    req = 1'b1; tick(); req = 1'b0;
    check("req_stamp_now", 32'(cnt),       32'd11);
    check("req_valid",     32'(out_valid), 32'h1);
    check("req_data",      32'(out_data),  32'h5A);
    check("req_stamp",     32'(out_stamp), 32'd10);
    check("req_level",     32'(level),     32'h1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("req_drain_lvl", 32'(level),     32'h0);
    check("req_drain_vld", 32'(out_valid), 32'h0);
    arm = 1'b0; tick();

    // Change mode: baseline 00, then 01 and 03.
    mode = 1'b1; R = 8'h00; tick();
    arm = 1'b1; tick();                   // now in BASE
    s0 = cnt;
    tick();                               // baseline captured
    tick(); tick(); tick(); tick();       // R steady for 5 cycles total
    R = 8'h01; sa = cnt; tick();
    R = 8'h03; tick();
    tick();                               // unchanged, no capture
    check("chg_level", 32'(level), 32'h3);
    arm = 1'b0; tick();
    check("chg_h0_data",  32'(out_data),  32'h00);
    check("chg_h0_stamp", 32'(out_stamp), 32'(s0));
    out_ready = 1'b1; tick();
    check("chg_h1_data",  32'(out_data),  32'h01);
    check("chg_h1_stamp", 32'(out_stamp), 32'(sa));
    tick();
    check("chg_h2_data",  32'(out_data),  32'h03);
    check("chg_h2_stamp", 32'(out_stamp), 32'(sa + 16'd1));
    tick(); out_ready = 1'b0;
    check("chg_empty", 32'(out_valid), 32'h0);

    // Overflow: 6 requests into a 4-deep buffer with no reader.
    mode = 1'b0; tick();
    arm = 1'b1; tick(); tick();           // BASE, then RUN
    for (int i = 0; i < 6; i++) begin
      R = 8'h10 + 8'(i); req = 1'b1; tick();
    end
    req = 1'b0;
    check("ovf_level", 32'(level),    32'h4);
    check("ovf_flag",  32'(overflow), 32'h1);
    check("ovf_head",  32'(out_data), 32'h10);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_clr",     32'(overflow), 32'h0);
    check("ovf_clr_lvl", 32'(level),    32'h4);

    // Full buffer with push and pop together: accepted, no overflow.
    R = 8'hAA; req = 1'b1; out_ready = 1'b1; tick();
    req = 1'b0; out_ready = 1'b0;
    check("fullpp_level", 32'(level),    32'h4);
    check("fullpp_ovf",   32'(overflow), 32'h0);
    check("fullpp_head",  32'(out_data), 32'h11);

    // Drop and clear in the same cycle: set wins.
    R = 8'hBB; req = 1'b1; clr_ovf = 1'b1; tick();
    req = 1'b0; clr_ovf = 1'b0;
    check("setclr_ovf", 32'(overflow), 32'h1);
    check("setclr_lvl", 32'(level),    32'h4);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("setclr_clr", 32'(overflow), 32'h0);

    exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'hAA;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), 32'(out_data), 32'(exp_q[i]));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'h0);

    // Stamp wrap: captures at FFFF and 0000 (still armed, request mode).
    while (cnt != 16'hFFFF) tick();
    R = 8'h77; req = 1'b1; tick();
    R = 8'h78; tick();
    req = 1'b0;
    check("wrap_level", 32'(level),     32'h2);
    check("wrap_s0",    32'(out_stamp), 32'hFFFF);
    check("wrap_d0",    32'(out_data),  32'h77);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("wrap_s1",    32'(out_stamp), 32'h0000);
    check("wrap_d1",    32'(out_data),  32'h78);
    R = 8'h79; req = 1'b1; tick();
    R = 8'h7A; tick();
    req = 1'b0;
    check("prerst_lvl", 32'(level), 32'h3);

    // Reset with 3 entries queued, then a fresh change-mode baseline.
    rst = 1'b1; mode = 1'b1; R = 8'hC3; tick();
    check("mrst_valid", 32'(out_valid), 32'h0);
    check("mrst_level", 32'(level),     32'h0);
    check("mrst_ovf",   32'(overflow),  32'h0);
    check("mrst_data",  32'(out_data),  32'h0);
    rst = 1'b0; tick(); tick();
    check("rearm_valid", 32'(out_valid), 32'h1);
    check("rearm_stamp", 32'(out_stamp), 32'h1);
    check("rearm_data",  32'(out_data),  32'hC3);
    check("rearm_level", 32'(level),     32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ixc_capture_8.md
# ixc_capture_8

Snapshot reader for an 8-bit emulated net: samples the value on a net driven by an 8-bit assign cell and queues time-stamped snapshots for the host-side readback path. It is the read-side counterpart of the assign template. It sits between the design net and the emulator's host readback channel, and delivers entries over a valid/ready stream. It supports on-request sampling and change-triggered sampling, with a small elastic buffer and a sticky overflow indication.

## Interface
Parameters:
- `WIDTH`, 8, width of the sampled net.
- `DEPTH`, 4, snapshot buffer entries; power of two, ≥2.
- `STAMP_W`, 16, width of the free-running cycle stamp.

Ports (clock and reset first):
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `R`  in  WIDTH  sampled net value.
- `arm`  in  1  level; 1 = capture enabled, 0 = capture stopped.
- `mode`  in  1  0 = request mode, 1 = change mode; sampled only while disarmed.
- `req`  in  1  one-cycle capture request (request mode only).
- `out_data`  out  WIDTH  head entry value.
- `out_stamp`  out  STAMP_W  head entry stamp.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer accepts head.
- `level`  out  clog2(DEPTH)+1  entries held.
- `overflow`  out  1  sticky: a capture was dropped.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `out_stamp`=0, `level`=0, `overflow`=0; stamp counter=0; FSM=IDLE.
- Stamp counter: increments every cycle after reset and wraps modulo 2^STAMP_W. A capture stores the counter value of its capture cycle.
- FSM states:
  - IDLE: no captures. `mode` is latched each cycle. On `arm`=1, go to BASE.
  - BASE: captures R unconditionally as the baseline, loads the previous-value register, then goes to RUN. In request mode, BASE captures only if `req`=1, and goes to RUN either way.
  - RUN, request mode: capture when `req`=1.
  - RUN, change mode: capture when R ≠ previous-value register; the previous-value register updates on every RUN cycle.
  - `arm`=0 in BASE or RUN: go to IDLE that cycle; no capture in that cycle.
- Push rule: a capture is written if `level`<DEPTH, or if a pop occurs in the same cycle. Otherwise the capture is dropped and `overflow` is set.
- `overflow` is cleared by `clr_ovf`. A set and a clear in the same cycle: set wins.
- Pop rule: the head is popped when `out_valid`&&`out_ready`.
- Buffer is first-word fall-through. `out_data`/`out_stamp` must hold stable while `out_valid`=1 and `out_ready`=0.
- Disarming does not flush the buffer; buffered entries still drain.
- `rst` mid-operation discards all entries and returns every output to its reset value on the next edge.

## Timing
- Capture at edge k → entry visible at the head by edge k+1 when the buffer was empty. With a non-empty buffer, it appears behind existing entries.
- Throughput: one push and one pop per cycle, sustained.
- `level` reflects pushes and pops on the edge they occur. Simultaneous push and pop leaves `level` unchanged.
- `mode` changes while armed are ignored until the next IDLE.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

## Structure
- Package `ixc_capture_pkg` contains:
  - FSM state enum {IDLE, BASE, RUN};
  - entry struct {stamp, data};
  - a `clog2`-based level-width constant.
- Sub-module `ixc_capture_fifo`: parameterised FWFT buffer of entries with push/pop/level/full/empty.
- The top level holds the FSM, stamp counter, previous-value register and overflow flag.

## Test plan
- Reset, then arm in request mode with R=8'h5A. Pulse `req` at stamp 10 → one entry {10, 8'h5A}; `out_valid` is high from stamp 11; `level`=1.
- Change mode, R steady at 8'h00 for 5 cycles, then 8'h01, 8'h03 → exactly 3 entries: baseline 8'h00, then 8'h01, then 8'h03, with consecutive stamps for the last two.
- `out_ready`=0 with DEPTH=4, 6 requests → `level`=4, `overflow`=1, and the first 4 values are retained in order. Pulse `clr_ovf` → `overflow`=0.
- Full buffer with `req` and `out_ready` both high in the same cycle → the new entry is accepted, `level` stays 4, and `overflow` stays 0.
- Set the stamp counter to 16'hFFFF and capture on two consecutive cycles → stamps 16'hFFFF then 16'h0000.
- Assert `rst` with 3 entries queued → next cycle `out_valid`=0, `level`=0, `overflow`=0; re-arming produces a fresh baseline at stamp 1.
